// File: rtl/mmio_bridge_pkg.sv
// Shared constants, types and helpers for the MMIO front end.
// No logic of its own; latency and backpressure are defined by the users.
// Port map: timer at byte 0x4000, keyboard at byte 0x4010 (word 0x1000 / 0x1004).
package mmio_pkg;

    localparam logic [31:0] TIMER_PORT  = 32'h0000_4000;
    localparam logic [31:0] KBD_PORT    = 32'h0000_4010;
    localparam logic [29:0] TIMER_WADDR = TIMER_PORT[31:2];
    localparam logic [29:0] KBD_WADDR   = KBD_PORT[31:2];

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_t;

    // Keyboard read word layout
    localparam int KBD_VLD_BIT  = 31;
    localparam int KBD_OVF_BIT  = 8;
    localparam int KBD_CODE_MSB = 7;
    localparam int KBD_CODE_LSB = 0;

    function automatic logic [31:0] kbd_word(input logic vld, input logic ovf,
                                             input logic [7:0] code);
        logic [31:0] w;
        w = '0;
        w[KBD_VLD_BIT]                 = vld;
        w[KBD_OVF_BIT]                 = ovf;
        w[KBD_CODE_MSB:KBD_CODE_LSB]   = code;
        return w;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU data port / cache-side bundle seen by the MMIO bridge.
// Combinational wires only; no latency of its own.
// Backpressure is the mem_stall_in / mem_stall pair carried here.
// slave: the bridge (takes CPU requests and cache responses, drives forwarded requests).
// master: the CPU + cache side driving requests and responses.
interface mmio_bridge_if;
    logic        dmem_read_in;
    logic        dmem_write_in;
    logic [29:0] dmem_addr;
    logic [31:0] data_from_reg;
    logic [3:0]  dc_byte_w_en;
    logic [31:0] mem_data_in;
    logic        mem_stall_in;
    logic        dc_read_out;
    logic        dc_write_out;
    logic [31:0] dmem_data_out;
    logic        mem_stall;

    modport slave (
        input  dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, dc_byte_w_en,
        input  mem_data_in, mem_stall_in,
        output dc_read_out, dc_write_out, dmem_data_out, mem_stall
    );

    modport master (
        output dmem_read_in, dmem_write_in, dmem_addr, data_from_reg, dc_byte_w_en,
        output mem_data_in, mem_stall_in,
        input  dc_read_out, dc_write_out, dmem_data_out, mem_stall
    );
endinterface

// File: rtl/mmio_bridge_kbd_fifo.sv
// Keyboard scancode FIFO with sticky overflow flag and synchronous flush.
// Head is combinational from storage; push/pop/flush take effect on the next edge.
// No backpressure: a push into a full FIFO (without a same-cycle pop) is dropped and sets ovf.
// Ports: clk, rst (sync active-low), push/push_code, pop, flush -> head, empty, full, ovf.
// KBD_DEPTH must be a power of 2 and at least 2.
module kbd_fifo #(
    parameter int KBD_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_code,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       ovf
);
    localparam int AW = $clog2(KBD_DEPTH);

    logic [7:0]    mem [KBD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(KBD_DEPTH));
    assign pop_ok  = pop & ~empty;
    // A same-cycle pop frees the slot the push needs.
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            if (push & ~push_ok) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok && !flush) mem[wr_ptr] <= push_code;
    end
endmodule

// File: rtl/mmio_bridge.sv
// MMIO front end: decodes timer/keyboard ports locally, passes everything else to the cache.
// I/O load: 1 stall cycle then registered data; I/O store: 0 stall cycles.
// Honours mem_stall_in: stores commit only on unstalled cycles; RESP holds data while stalled.
// Ports: clk, rst (sync active-low), bus (CPU/cache bundle, slave view), kbd_valid/kbd_code.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int KBD_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    mmio_bridge_if.slave bus,
    input  logic         kbd_valid,
    input  logic [7:0]   kbd_code
);
    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic            is_timer, is_kbd, is_io;
    logic            io_stall, stall_out, commit;
    logic            timer_wr, kbd_flush;
    logic [PW-1:0]   presc;
    logic [31:0]     timer;
    rd_state_t       state_q, state_d;
    logic            capture, pop;
    logic [31:0]     io_rdata;
    logic            pop_pend;
    logic [7:0]      kbd_head;
    logic            kbd_empty, kbd_full, kbd_ovf;

    // Decode and pass-through
    assign is_timer = (bus.dmem_addr == TIMER_WADDR);
    assign is_kbd   = (bus.dmem_addr == KBD_WADDR);
    assign is_io    = is_timer | is_kbd;

    assign bus.dc_read_out   = bus.dmem_read_in  & ~is_io;
    assign bus.dc_write_out  = bus.dmem_write_in & ~is_io;
    assign stall_out         = bus.mem_stall_in | io_stall;
    assign bus.mem_stall     = stall_out;
    assign bus.dmem_data_out = (state_q == RESP) ? io_rdata : bus.mem_data_in;

    // The CPU repeats a stalled store, so only the unstalled cycle may take effect.
    assign commit    = ~stall_out;
    assign timer_wr  = bus.dmem_write_in & is_timer & commit;
    assign kbd_flush = bus.dmem_write_in & is_kbd   & commit;

    // Timer: a store overrides a same-cycle increment and restarts the prescaler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            timer <= '0;
        end else if (timer_wr) begin
            presc <= '0;
            timer <= byte_merge(timer, bus.data_from_reg, bus.dc_byte_w_en);
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            timer <= timer + 32'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Read FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.dmem_read_in && is_io) state_d = RESP;
            RESP: if (!bus.mem_stall_in)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        io_stall = 1'b0;
        capture  = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                io_stall = bus.dmem_read_in & is_io;
                capture  = bus.dmem_read_in & is_io;
            end
            // Pop on the cycle the CPU actually consumes the data.
            RESP: pop = pop_pend & ~bus.mem_stall_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            io_rdata <= '0;
            pop_pend <= 1'b0;
        end else if (capture) begin
            io_rdata <= is_timer ? timer : kbd_word(~kbd_empty, kbd_ovf, kbd_head);
            pop_pend <= is_kbd & ~kbd_empty;
        end
    end

    kbd_fifo #(.KBD_DEPTH(KBD_DEPTH)) u_kbd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (kbd_valid),
        .push_code (kbd_code),
        .pop       (pop),
        .flush     (kbd_flush),
        .head      (kbd_head),
        .empty     (kbd_empty),
        .full      (kbd_full),
        .ovf       (kbd_ovf)
    );
endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: vector table, directed corner sequences, then random operations
// checked against a queue/arithmetic reference model of the timer and keyboard ports.
module tb_mmio_bridge;
    import mmio_pkg::*;

    localparam int TD = 4;
    localparam int KD = 8;

    logic clk = 1'b0;
    logic rst;
    logic kbd_valid;
    logic [7:0] kbd_code;
    always #5 clk = ~clk;

    mmio_bridge_if bus();

    mmio_bridge #(.TICK_DIV(TD), .KBD_DEPTH(KD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: timer = anchor value + elapsed edges / TD; keyboard = bounded queue.
    logic [7:0]  mq[$];
    bit          movf;
    int          anc_cyc;
    logic [31:0] anc_val;

    function automatic logic [31:0] m_timer(input int c);
        return anc_val + 32'((c - anc_cyc) / TD);
    endfunction

    function automatic logic [31:0] m_kbd();
        if (mq.size() > 0) return {1'b1, 22'b0, movf, mq[0]};
        return {1'b0, 22'b0, movf, 8'h00};
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic m_push(input logic [7:0] code);
        if (mq.size() < KD) mq.push_back(code);
        else movf = 1'b1;
    endtask

    // Store issued in the cycle whose upcoming edge is c+1.
    task automatic m_store(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be,
                           input int c);
        if (a == TIMER_WADDR) begin
            anc_val = m_merge(m_timer(c), d, be);
            anc_cyc = c + 1;
        end else if (a == KBD_WADDR) begin
            mq.delete();
            movf = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        bus.dmem_read_in  = 1'b0;
        bus.dmem_write_in = 1'b0;
        bus.dmem_addr     = '0;
        bus.data_from_reg = '0;
        bus.dc_byte_w_en  = '0;
        bus.mem_data_in   = $urandom;
        bus.mem_stall_in  = 1'b0;
        kbd_valid         = 1'b0;
        kbd_code          = '0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
        anc_cyc = cyc;
        anc_val = '0;
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_idle();
        end
    endtask

    task automatic push(input logic [7:0] code);
        @(negedge clk);
        drive_idle();
        kbd_valid = 1'b1;
        kbd_code  = code;
        m_push(code);
    endtask

    // I/O load: IDLE cycle, optional stalled RESP cycles, final RESP cycle (optional push).
    task automatic io_load(input logic [29:0] a, input int stalls, input bit push_en,
                           input logic [7:0] pcode, output logic [31:0] got);
        logic [31:0] exp;
        @(negedge clk);
        drive_idle();
        bus.dmem_read_in = 1'b1;
        bus.dmem_addr    = a;
        exp = (a == TIMER_WADDR) ? m_timer(cyc) : m_kbd();
        #1;
        chk("io_load_stall", {31'b0, bus.mem_stall}, 32'd1);
        chk("io_load_dc_read", {31'b0, bus.dc_read_out}, 32'd0);
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            bus.mem_stall_in = 1'b1;
            bus.mem_data_in  = $urandom;
            #1;
            chk("resp_stall_held", {31'b0, bus.mem_stall}, 32'd1);
            chk("resp_data_held", bus.dmem_data_out, exp);
        end
        @(negedge clk);
        bus.mem_stall_in = 1'b0;
        bus.mem_data_in  = $urandom;
        kbd_valid = push_en;
        kbd_code  = pcode;
        #1;
        chk("resp_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("io_load_data", bus.dmem_data_out, exp);
        got = bus.dmem_data_out;
        if (a == KBD_WADDR && mq.size() > 0) void'(mq.pop_front());
        if (push_en) m_push(pcode);
    endtask

    task automatic io_store(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be,
                            input logic sin);
        @(negedge clk);
        drive_idle();
        bus.dmem_write_in = 1'b1;
        bus.dmem_addr     = a;
        bus.data_from_reg = d;
        bus.dc_byte_w_en  = be;
        bus.mem_stall_in  = sin;
        #1;
        chk("io_store_stall", {31'b0, bus.mem_stall}, {31'b0, sin});
        chk("io_store_dc_write", {31'b0, bus.dc_write_out}, 32'd0);
        if (!sin) m_store(a, d, be, cyc);
    endtask

    task automatic pass_op(input logic rd, input logic wr, input logic [29:0] a,
                           input logic sin);
        @(negedge clk);
        drive_idle();
        bus.dmem_read_in  = rd;
        bus.dmem_write_in = wr;
        bus.dmem_addr     = a;
        bus.data_from_reg = $urandom;
        bus.dc_byte_w_en  = 4'($urandom);
        bus.mem_stall_in  = sin;
        #1;
        chk("pass_dc_read", {31'b0, bus.dc_read_out}, {31'b0, rd});
        chk("pass_dc_write", {31'b0, bus.dc_write_out}, {31'b0, wr});
        chk("pass_stall", {31'b0, bus.mem_stall}, {31'b0, sin});
        chk("pass_data", bus.dmem_data_out, bus.mem_data_in);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic        sin;
        logic        exp_dcr;
        logic        exp_dcw;
        logic        exp_stall;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[12];
        logic [31:0] got;
        logic [31:0] d;
        int          e;

        rst = 1'b0;
        drive_idle();
        do_reset(3);

        vt[0]  = '{1'b1, 1'b0, 30'h0002000, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 30'h0000FFF, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 30'h0001001, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 30'h0001003, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 30'h0001005, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 30'h0001004, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 30'h0001000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 30'h3FFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 30'h0003000, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 30'h0001000, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 30'h0001000, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 30'h2001000, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_idle();
            bus.dmem_read_in  = vt[i].rd;
            bus.dmem_write_in = vt[i].wr;
            bus.dmem_addr     = vt[i].addr;
            bus.data_from_reg = $urandom;
            bus.dc_byte_w_en  = 4'($urandom);
            bus.mem_stall_in  = vt[i].sin;
            #1;
            chk($sformatf("vec%0d_dc_read", i), {31'b0, bus.dc_read_out}, {31'b0, vt[i].exp_dcr});
            chk($sformatf("vec%0d_dc_write", i), {31'b0, bus.dc_write_out}, {31'b0, vt[i].exp_dcw});
            chk($sformatf("vec%0d_stall", i), {31'b0, bus.mem_stall}, {31'b0, vt[i].exp_stall});
            chk($sformatf("vec%0d_data", i), bus.dmem_data_out, bus.mem_data_in);
            if (vt[i].wr && !vt[i].sin)
                m_store(vt[i].addr, bus.data_from_reg, bus.dc_byte_w_en, cyc);
        end
        io_load(TIMER_WADDR, 0, 1'b0, 8'h00, got);

        // Timer count from reset
        do_reset(2);
        e = cyc;
        while (cyc < e + 39) @(negedge clk);
        io_load(TIMER_WADDR, 0, 1'b0, 8'h00, got);
        chk("timer_after_40", got, 32'd10);

        // Partial timer store
        io_store(TIMER_WADDR, 32'hAABBCCDD, 4'hF, 1'b0);
        io_store(TIMER_WADDR, 32'h12345678, 4'b0011, 1'b0);
        io_load(TIMER_WADDR, 0, 1'b0, 8'h00, got);
        chk("timer_byte_store", got, 32'hAABB5678);

        // FIFO order
        io_store(KBD_WADDR, 32'h0, 4'hF, 1'b0);
        push(8'h1C); push(8'h32); push(8'h21);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_order0", got, 32'h8000001C);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_order1", got, 32'h80000032);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_order2", got, 32'h80000021);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_empty", got, 32'h00000000);

        // Overflow, then flush by store
        for (int i = 0; i < 9; i++) push(8'h1C + 8'(i));
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_ovf", got, 32'h8000011C);
        io_store(KBD_WADDR, 32'hFFFFFFFF, 4'hF, 1'b0);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("fifo_flushed", got, 32'h00000000);

        // Long stall in RESP pops exactly once
        push(8'hA1); push(8'hB2);
        io_load(KBD_WADDR, 5, 1'b0, 8'h00, got); chk("stall_first", got, 32'h800000A1);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("stall_one_pop", got, 32'h800000B2);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("stall_then_empty", got, 32'h00000000);

        // Push into empty FIFO during RESP leaves the captured response empty
        io_load(KBD_WADDR, 0, 1'b1, 8'h55, got); chk("push_in_resp_empty", got, 32'h00000000);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("push_in_resp_kept", got, 32'h80000055);

        // Push and pop in the same cycle
        push(8'h11);
        io_load(KBD_WADDR, 0, 1'b1, 8'h22, got); chk("pushpop_head", got, 32'h80000011);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("pushpop_next", got, 32'h80000022);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("pushpop_empty", got, 32'h00000000);

        // Reset while in RESP
        push(8'h77);
        idle_cycles(6);
        @(negedge clk);
        drive_idle();
        bus.dmem_read_in = 1'b1;
        bus.dmem_addr    = KBD_WADDR;
        @(negedge clk);
        bus.mem_stall_in = 1'b1;
        #1;
        chk("rst_pre_resp_data", bus.dmem_data_out, 32'h80000077);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        anc_cyc = cyc;
        anc_val = '0;
        mq.delete();
        movf = 1'b0;
        drive_idle();
        #1;
        chk("rst_idle_stall", {31'b0, bus.mem_stall}, 32'd0);
        chk("rst_idle_data", bus.dmem_data_out, bus.mem_data_in);
        io_load(TIMER_WADDR, 0, 1'b0, 8'h00, got); chk("rst_timer_zero", got, 32'h0);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got); chk("rst_fifo_empty", got, 32'h0);
        pass_op(1'b1, 1'b0, 30'h0002000, 1'b0);

        // Random operations against the model
        for (int n = 0; n < 400; n++) begin
            logic [29:0] a;
            a = 30'($urandom);
            if (a == TIMER_WADDR || a == KBD_WADDR) a = 30'h0002000;
            case ($urandom_range(0, 7))
                0, 1: push(8'($urandom));
                2: io_load(TIMER_WADDR, $urandom_range(0, 3), 1'($urandom), 8'($urandom), got);
                3: io_load(KBD_WADDR, $urandom_range(0, 3), 1'($urandom), 8'($urandom), got);
                4: begin
                    d = $urandom;
                    io_store(TIMER_WADDR, d, 4'($urandom), ($urandom_range(0, 3) == 0));
                end
                5: io_store(KBD_WADDR, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0));
                6: pass_op(1'($urandom), 1'($urandom), a, 1'($urandom));
                default: idle_cycles($urandom_range(0, 5));
            endcase
        end
        io_load(TIMER_WADDR, 0, 1'b0, 8'h00, got);
        io_load(KBD_WADDR, 0, 1'b0, 8'h00, got);
        idle_cycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
